// File: rtl/req_ack_responder.sv
// Responder side of a req/ack handshake: programmable latency, backend gating,
// hard timeout and overlap error. Abort support is enabled by REQ_ACK_RESPONDER_ABORT_EN.
module req_ack_responder #(
  parameter int unsigned LAT_W   = 4,
  parameter int unsigned MAX_LAT = 10,
  parameter int unsigned TIMEOUT = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [LAT_W-1:0] lat_cfg,
  input  logic             grant_ready,
  input  logic             abort_sig,
  output logic             ack,
  output logic             error,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned AGE_W = $clog2(TIMEOUT + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(TIMEOUT);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(MAX_LAT);

  // Parameter sanity checks at elaboration
  if (MAX_LAT < 1 || MAX_LAT > ((1 << LAT_W) - 1)) begin : g_bad_max_lat
    $error("req_ack_responder: MAX_LAT out of range 1..2**LAT_W-1");
  end
  if (TIMEOUT <= MAX_LAT) begin : g_bad_timeout
    $error("req_ack_responder: TIMEOUT must be greater than MAX_LAT");
  end

  logic             abort_act;
`ifdef REQ_ACK_RESPONDER_ABORT_EN
  assign abort_act = abort_sig;
`else
  logic unused_abort;
  assign unused_abort = abort_sig;
  assign abort_act    = 1'b0;
`endif

  logic [0:0]       state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [AGE_W-1:0] lat_m1_q, lat_m1_d;
  logic             ack_q, ack_d;
  logic             error_q, error_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;

  logic [LAT_W-1:0] lat_eff;
  logic [AGE_W-1:0] lat_m1_new;

  // Clamp requested latency to 1..MAX_LAT; stored as L-1 to compare against age
  always_comb begin
    lat_eff = lat_cfg;
    if (lat_cfg == '0) begin
      lat_eff = LAT_W'(1);
    end else if (lat_cfg > LAT_MAX) begin
      lat_eff = LAT_MAX;
    end
    lat_m1_new = AGE_W'(lat_eff - LAT_W'(1));
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    age_d     = age_q;
    lat_m1_d  = lat_m1_q;
    ack_d     = 1'b0;
    error_d   = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req && !abort_act) begin
          lat_m1_d = lat_m1_new;
          // L=1 with backend ready completes without entering WAIT
          if (lat_m1_new == '0 && grant_ready) begin
            ack_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            age_d   = AGE_W'(1);
          end
        end
      end
      S_WAIT: begin
        error_d = req && !abort_act;
        if (abort_act) begin
          state_d = S_IDLE;
          age_d   = '0;
        end else if (age_q >= lat_m1_q && grant_ready) begin
          ack_d   = 1'b1;
          state_d = S_IDLE;
          age_d   = '0;
        end else if (age_q >= AGE_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
          age_d     = '0;
        end else if (age_q != AGE_SAT) begin
          age_d = age_q + AGE_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        age_d   = '0;
      end
    endcase

    busy_d = (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      age_q     <= '0;
      lat_m1_q  <= '0;
      ack_q     <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      age_q     <= age_d;
      lat_m1_q  <= lat_m1_d;
      ack_q     <= ack_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign ack     = ack_q;
  assign error   = error_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;

endmodule

// File: doc/req_ack_responder.md
# req_ack_responder

Responder end of the req/ack handshake that the SVA property suite checks. It accepts a single-cycle-sampled request and answers with a one-cycle `ack` after a programmable latency, gated by a backend-ready input. It supports abort cancellation, a hard response timeout and error flagging of overlapping requests. It sits in front of a backend resource and is the DUT side that the accept_on/reject_on/sync_* properties are bound against.

## Interface
- `LAT_W`, default 4: width of `lat_cfg`.
- `MAX_LAT`, default 10: maximum request-to-ack latency in cycles. Legal range 1..2**LAT_W−1.
- `TIMEOUT`, default 20: cycles after acceptance at which an unanswered request is abandoned. Must be greater than `MAX_LAT`; elaboration error otherwise.
- `clk` in 1: sole clock; all logic on posedge.
- `rst` in 1: synchronous reset, active-high.
- `req` in 1: request, sampled each cycle.
- `lat_cfg` in LAT_W: requested latency, sampled only in the acceptance cycle.
- `grant_ready` in 1: backend can complete this cycle.
- `abort_sig` in 1: cancel the pending request.
- `ack` out 1: registered, one-cycle completion pulse.
- `error` out 1: registered, one-cycle pulse; request dropped because responder busy.
- `timeout` out 1: registered, one-cycle pulse; request abandoned.
- `busy` out 1: registered; high while a request is pending.

## Operation
- States are IDLE and WAIT. `busy` = (state == WAIT).
- Reset: state IDLE, counters 0, and `ack`/`error`/`timeout`/`busy` all 0 from the cycle after `rst` is sampled high. `rst` overrides every other input, including mid-request; no ack is emitted for a request in flight at reset.
- Acceptance happens in cycle n when state is IDLE, `req`=1 and abort is not active.
  - Effective latency L = clamp(`lat_cfg`): 0 becomes 1, values above `MAX_LAT` become `MAX_LAT`.
  - The age counter starts.
  - When abort is active (`abort_sig`=1 with the macro defined) in cycle n, the request is ignored: no state change and no error.
- Decision cycle D is the first cycle ≥ n+L−1 in which `grant_ready`=1. For L=1 this can be cycle n itself, in which case the FSM stays IDLE.
  - `ack`=1 in cycle D+1.
  - State is IDLE in cycle D+1, so a `req` in cycle D+1 is accepted (back-to-back).
- Timeout: if no D exists by cycle n+TIMEOUT−1, `timeout`=1 in cycle n+TIMEOUT, state returns to IDLE and no ack is issued for that request.
- Abort: `abort_sig`=1 in any cycle n+1..D cancels the request.
  - Abort in cycle D wins over ack.
  - State is IDLE the next cycle. No ack, no error, no timeout.
- Overlap: `req`=1 in cycles n+1..D while WAIT gives `error`=1 the following cycle. The new request is dropped and the pending request is unaffected.
- Priority per cycle: rst > abort > ack decision > timeout > error.
- Counters saturate. Age width is clog2(TIMEOUT+1) and does not wrap.

## Timing
- Minimum latency: `req` in cycle n gives `ack` in n+1 (L=1, `grant_ready`=1).
- Nominal latency: `ack` in n+L with `grant_ready` held high.
- `ack`, `error` and `timeout` are never high for more than one cycle each.
- `ack` and `timeout` are mutually exclusive for a given request.
- `busy` falls in the same cycle that `ack` or `timeout` rises, or in the cycle after an abort.

## Configuration
- `REQ_ACK_RESPONDER_ABORT_EN`
  - Defined: `abort_sig` is honoured as specified above.
  - Undefined: `abort_sig` is ignored (port kept, unconnected internally). Requests complete only via ack or timeout.

## Test plan
Defaults for all scenarios: MAX_LAT=10, TIMEOUT=20, `grant_ready`=1 unless stated, `req` pulsed in cycle 0.
- Reset and nominal path: `rst`=1 for 2 cycles with `req`=1 → all outputs 0. Then `req` in cycle 0, `lat_cfg`=3 → `busy` in cycles 1–2, `ack` only in cycle 3.
- Clamp: `lat_cfg`=0 → `ack` in cycle 1. `lat_cfg`=15 → `ack` in cycle 10.
- Backpressure and timeout:
  - `lat_cfg`=3, `grant_ready` low until cycle 7 → `ack` in cycle 8.
  - `grant_ready` never high → `timeout` in cycle 20, no ack, `busy` low from cycle 20.
- Abort (macro defined):
  - `lat_cfg`=5, `abort_sig` in cycle 2 → no ack, `busy` 0 in cycle 3.
  - `abort_sig` in cycle 4 (decision cycle) → no ack.
  - Macro undefined, same stimulus → `ack` in cycle 5.
- Overlap and back-to-back: `lat_cfg`=3, `req` again in cycle 1 → `error` in cycle 2, `ack` still in cycle 3. `req` in cycle 3 → accepted, `ack` in cycle 6.
- Reset mid-operation: `lat_cfg`=5, `rst` in cycle 2 → all outputs 0 from cycle 3, no ack in cycle 5.
